// File: rtl/fdtd_pkg.sv
// Shared FDTD types: writeback FSM states and
// saturating arithmetic used by the field writebacks.
package fdtd_pkg;

  localparam int DATA_W = 32;

  typedef logic signed [DATA_W-1:0] fdtd_data_t;

  localparam fdtd_data_t FDTD_MAX =
    {1'b0, {(DATA_W-1){1'b1}}};
  localparam fdtd_data_t FDTD_MIN =
    {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } wb_state_e;

  typedef struct packed {
    logic       sat;
    fdtd_data_t val;
  } sat_res_t;

  function automatic sat_res_t sat_add(
    input fdtd_data_t a,
    input fdtd_data_t b
  );
    logic signed [DATA_W:0] s;
    sat_res_t r;
    s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    r.sat = s[DATA_W] ^ s[DATA_W-1];
    r.val = s[DATA_W-1:0];
    if (r.sat)
      r.val = s[DATA_W] ? FDTD_MIN : FDTD_MAX;
    return r;
  endfunction

endpackage

// File: rtl/fdtd_ez_writeback_if.sv
// Ez field RAM write port.
// The writeback drives it as master.
interface fdtd_ez_writeback_if
  import fdtd_pkg::*;
#(
  parameter int ADDR_WIDTH      = 10,
  parameter int FDTD_DATA_WIDTH = DATA_W
);
  logic                              wr_en;
  logic [ADDR_WIDTH-1:0]             wr_addr;
  logic signed [FDTD_DATA_WIDTH-1:0] wr_data;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input wr_en,
    input wr_addr,
    input wr_data
  );
endinterface

// File: rtl/fdtd_data_delay.sv
// Fixed-length register delay line, cleared on reset.
// Used to track calc-stage valids through its latency.
module fdtd_data_delay #(
  parameter int FDTD_DATA_WIDTH = 1,
  parameter int DELAY_STAGE     = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [FDTD_DATA_WIDTH-1:0] din,
  output logic [FDTD_DATA_WIDTH-1:0] dout
);

  logic [FDTD_DATA_WIDTH-1:0] pipe [DELAY_STAGE];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DELAY_STAGE; i++)
        pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DELAY_STAGE; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DELAY_STAGE-1];

endmodule

// File: rtl/fdtd_ez_writeback.sv
// Ez writeback: PEC and source injection on calc
// results, Ez RAM write and sweep completion.
module fdtd_ez_writeback
  import fdtd_pkg::*;
#(
  parameter int FDTD_DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH      = 10,
  parameter int CALC_LATENCY    = 4
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic                              start_i,
  input  logic [ADDR_WIDTH-1:0]             n_cells_i,
  input  logic                              clken_i,
  input  logic signed [FDTD_DATA_WIDTH-1:0] ez_n_i,
  input  logic                              pec_en_i,
  input  logic                              src_en_i,
  input  logic [ADDR_WIDTH-1:0]             src_idx_i,
  input  logic signed [FDTD_DATA_WIDTH-1:0] src_val_i,
  fdtd_ez_writeback_if.master               wr,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              sat_o
);

  wb_state_e state, state_nx;

  logic [ADDR_WIDTH-1:0] n_cells, src_idx;
  logic [ADDR_WIDTH-1:0] issue_cnt, wr_cnt;
  logic                  pec_en, src_en;
  fdtd_data_t            src_val;

  logic                  wr_en_q, sat_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  fdtd_data_t            wr_data_q;

  logic       accept, tag_in, tag_out, last_wr;
  logic       is_pec, is_src, wr_sat;
  sat_res_t   sum;
  fdtd_data_t wr_val;

  assign accept  = (state == ST_IDLE) && start_i;
  assign tag_in  = (state == ST_RUN) && clken_i
                   && (issue_cnt < n_cells);
  assign last_wr = wr_en_q
                   && (wr_addr_q == n_cells - 1'b1);

  fdtd_data_delay #(
    .FDTD_DATA_WIDTH (1),
    .DELAY_STAGE     (CALC_LATENCY)
  ) u_tag (
    .CLK   (CLK),
    .RST_N (RST_N),
    .din   (tag_in),
    .dout  (tag_out)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:
        if (start_i)
          state_nx = (n_cells_i == '0) ? ST_DONE
                                       : ST_RUN;
      ST_RUN:
        if (last_wr) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // PEC wins over the source when both hit a cell
  always_comb begin
    is_pec = pec_en && ((wr_cnt == '0)
             || (wr_cnt == n_cells - 1'b1));
    is_src = src_en && (wr_cnt == src_idx);
    sum    = sat_add(ez_n_i, src_val);
    wr_val = ez_n_i;
    wr_sat = 1'b0;
    priority case (1'b1)
      is_pec: wr_val = '0;
      is_src: begin
        wr_val = sum.val;
        wr_sat = sum.sat;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      n_cells   <= '0;
      src_idx   <= '0;
      pec_en    <= 1'b0;
      src_en    <= 1'b0;
      src_val   <= '0;
      issue_cnt <= '0;
      wr_cnt    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      sat_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      if (accept) begin
        n_cells   <= n_cells_i;
        pec_en    <= pec_en_i;
        src_en    <= src_en_i;
        src_idx   <= src_idx_i;
        src_val   <= src_val_i;
        issue_cnt <= '0;
        wr_cnt    <= '0;
        sat_q     <= 1'b0;
      end
      if (tag_in)
        issue_cnt <= issue_cnt + 1'b1;
      if ((state == ST_RUN) && tag_out) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= wr_cnt;
        wr_data_q <= wr_val;
        wr_cnt    <= wr_cnt + 1'b1;
        if (wr_sat) sat_q <= 1'b1;
      end
    end
  end

  assign wr.wr_en   = wr_en_q;
  assign wr.wr_addr = wr_addr_q;
  assign wr.wr_data = wr_data_q;
  assign busy_o     = (state == ST_RUN);
  assign done_o     = (state == ST_DONE);
  assign sat_o      = sat_q;

endmodule

// File: tb/tb_fdtd_ez_writeback.sv
// Bench for fdtd_ez_writeback: directed and random
// sweeps against a cycle-scheduled reference model.
module tb_fdtd_ez_writeback;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int L  = 4;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic                 CLK = 1'b0;
  logic                 RST_N;
  logic                 start_i;
  logic [AW-1:0]        n_cells_i;
  logic                 clken_i;
  logic signed [DW-1:0] ez_n_i;
  logic                 pec_en_i;
  logic                 src_en_i;
  logic [AW-1:0]        src_idx_i;
  logic signed [DW-1:0] src_val_i;
  logic                 busy_o, done_o, sat_o;

  fdtd_ez_writeback_if #(
    .ADDR_WIDTH      (AW),
    .FDTD_DATA_WIDTH (DW)
  ) wr_if ();

  fdtd_ez_writeback #(
    .FDTD_DATA_WIDTH (DW),
    .ADDR_WIDTH      (AW),
    .CALC_LATENCY    (L)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .start_i   (start_i),
    .n_cells_i (n_cells_i),
    .clken_i   (clken_i),
    .ez_n_i    (ez_n_i),
    .pec_en_i  (pec_en_i),
    .src_en_i  (src_en_i),
    .src_idx_i (src_idx_i),
    .src_val_i (src_val_i),
    .wr        (wr_if),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .sat_o     (sat_o)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  int n_g, sidx_g, sval_g;
  bit pec_g, src_g, prev_sat;
  int ez_q[$];
  bit pat_q[$];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Reference rule for one cell's written value
  function automatic int model(input int k, input int ez,
                               output bit s);
    longint sm;
    s = 1'b0;
    if (pec_g && (k == 0 || k == n_g - 1))
      return 0;
    if (src_g && k == sidx_g) begin
      sm = longint'(ez) + longint'(sval_g);
      if (sm > MAXV) begin s = 1'b1; sm = MAXV; end
      if (sm < MINV) begin s = 1'b1; sm = MINV; end
      return int'(sm);
    end
    return ez;
  endfunction

  task automatic setup(input int n, input bit pec,
                       input bit src, input int sidx,
                       input int sval);
    n_g = n; pec_g = pec; src_g = src;
    sidx_g = sidx; sval_g = sval;
    ez_q.delete();
    pat_q.delete();
  endtask

  task automatic fill_ones(input int k);
    for (int i = 0; i < k; i++) pat_q.push_back(1'b1);
  endtask

  // Caller is at a negedge; cycle 0 carries the start
  task automatic run_sweep(input int abort_cyc,
                           input bit extra_start);
    int sez[256];
    bit sv[256], ew[256];
    int ea[256], ed[256];
    int issued, last, done_c, sat_c, h, c;
    bit s;
    for (int i = 0; i < 256; i++) begin
      sez[i] = 0; sv[i] = 0; ew[i] = 0;
      ea[i] = 0; ed[i] = 0;
    end
    issued = 0; last = -1; sat_c = -1;
    for (int t = 0; t < pat_q.size(); t++) begin
      if (pat_q[t] && issued < n_g) begin
        c = t + 1;
        sv[c+L]    = 1'b1;
        sez[c+L]   = ez_q[issued];
        ew[c+L+1]  = 1'b1;
        ea[c+L+1]  = issued;
        ed[c+L+1]  = model(issued, ez_q[issued], s);
        if (s && sat_c < 0) sat_c = c + L + 1;
        last = c + L + 1;
        issued++;
      end
    end
    done_c = (n_g == 0) ? 1 : last + 1;
    h = done_c + 2;
    for (int cy = 0; cy <= h; cy++) begin
      if (cy == abort_cyc) begin
        RST_N = 1'b0; start_i = 1'b0; clken_i = 1'b0;
        #1;
        check("rst_wr_en", wr_if.wr_en, 0);
        check("rst_wr_addr", wr_if.wr_addr, 0);
        check("rst_wr_data", wr_if.wr_data, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_sat", sat_o, 0);
        repeat (3) begin
          @(negedge CLK);
          check("abort_wr_en", wr_if.wr_en, 0);
          check("abort_done", done_o, 0);
        end
        RST_N = 1'b1;
        prev_sat = 1'b0;
        return;
      end
      check("wr_en", wr_if.wr_en, ew[cy]);
      if (ew[cy]) begin
        check("wr_addr", wr_if.wr_addr, ea[cy]);
        check("wr_data", wr_if.wr_data, ed[cy]);
      end
      check("busy", busy_o, (cy >= 1 && cy < done_c));
      check("done", done_o, (cy == done_c));
      check("sat", sat_o, (cy == 0) ? prev_sat
            : (sat_c >= 0 && cy >= sat_c));
      start_i   = (cy == 0) || (extra_start && cy == 2);
      n_cells_i = (cy == 0) ? AW'(n_g) : AW'($urandom);
      pec_en_i  = (cy == 0) ? pec_g : 1'($urandom);
      src_en_i  = (cy == 0) ? src_g : 1'($urandom);
      src_idx_i = (cy == 0) ? AW'(sidx_g) : AW'($urandom);
      src_val_i = (cy == 0) ? sval_g : $urandom;
      clken_i   = (cy >= 1 && cy - 1 < pat_q.size())
                  ? pat_q[cy-1] : 1'b0;
      ez_n_i    = sv[cy] ? sez[cy] : $urandom;
      @(negedge CLK);
    end
    start_i  = 1'b0;
    clken_i  = 1'b0;
    prev_sat = (sat_c >= 0);
  endtask

  initial begin
    int n, x;
    RST_N = 1'b0; start_i = 1'b0; n_cells_i = '0;
    clken_i = 1'b0; ez_n_i = '0; pec_en_i = 1'b0;
    src_en_i = 1'b0; src_idx_i = '0; src_val_i = '0;
    prev_sat = 1'b0;
    repeat (2) @(negedge CLK);
    check("reset_wr_en", wr_if.wr_en, 0);
    check("reset_wr_addr", wr_if.wr_addr, 0);
    check("reset_wr_data", wr_if.wr_data, 0);
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    check("reset_sat", sat_o, 0);
    RST_N = 1'b1;
    @(negedge CLK);

    setup(5, 0, 0, 0, 0);
    ez_q = '{10, 20, 30, 40, 50}; fill_ones(5);
    run_sweep(-1, 0);

    setup(4, 0, 1, 2, 32'h7FFF_FFF0);
    ez_q = '{1, 2, 32'h20, 3}; fill_ones(4);
    run_sweep(-1, 0);

    setup(4, 1, 0, 0, 0);
    ez_q = '{7, 8, 9, 10}; fill_ones(4);
    run_sweep(-1, 0);

    setup(3, 0, 1, 1, 32'h8000_0010);
    ez_q = '{5, -32, 6}; fill_ones(3);
    run_sweep(-1, 0);

    setup(3, 0, 1, 7, 1000);
    ez_q = '{11, 22, 33};
    pat_q = '{1, 0, 1, 1, 1};
    run_sweep(-1, 1);

    setup(0, 1, 1, 0, 5);
    run_sweep(-1, 0);

    setup(6, 0, 0, 0, 0);
    ez_q = '{1, 2, 3, 4, 5, 6}; fill_ones(6);
    run_sweep(8, 0);

    setup(5, 0, 0, 0, 0);
    ez_q = '{10, 20, 30, 40, 50}; fill_ones(5);
    run_sweep(-1, 0);

    for (int r = 0; r < 16; r++) begin
      n = $urandom_range(1, 10);
      x = (r % 4 == 0) ? int'($urandom)
          : $urandom_range(0, 2000) - 1000;
      setup(n, 1'($urandom), 1'($urandom),
            $urandom_range(0, n + 1), x);
      for (int i = 0; i < n; i++)
        ez_q.push_back(int'($urandom));
      x = 0;
      while (x < n + $urandom_range(0, 2)) begin
        pat_q.push_back($urandom_range(0, 3) != 0);
        if (pat_q[pat_q.size()-1]) x++;
      end
      run_sweep(-1, (r % 3 == 0));
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/fdtd_ez_writeback.md
# fdtd_ez_writeback

Downstream stage of the Ez update pipeline: consumes the Ez(n) samples produced by the Ez calculation stage and applies the PEC boundary and the soft/hard source injection. It writes the results into the Ez field RAM and signals completion of one time-step sweep to the FDTD controller. Output alignment is by a valid tag that tracks each `clken` issued to the calculation stage through its fixed pipeline latency.

## Interface
- `FDTD_DATA_WIDTH`, 32, signed field sample width.
- `ADDR_WIDTH`, 10, Ez RAM address and cell-index width.
- `CALC_LATENCY`, 4, cycles from `clken` into the calc stage to its matching valid `Ez_n` output; must be ≥1.
- `CLK` in 1: clock.
- `RST_N` in 1: reset, asynchronous, active-low.
- `start_i` in 1: one-cycle pulse that begins a sweep.
- `n_cells_i` in ADDR_WIDTH: cell count, latched on an accepted start.
- `clken_i` in 1: the same strobe driven into the calc stage; each high cycle is one issued cell.
- `ez_n_i` in FDTD_DATA_WIDTH: Ez(n) from the calc stage.
- `pec_en_i` in 1: force cells 0 and n_cells-1 to zero.
- `src_en_i` in 1: enable source injection.
- `src_idx_i` in ADDR_WIDTH: source cell index.
- `src_val_i` in FDTD_DATA_WIDTH: signed value added at the source cell.
- `wr_en_o` out 1: Ez RAM write strobe.
- `wr_addr_o` out ADDR_WIDTH: write address, equal to the cell index.
- `wr_data_o` out FDTD_DATA_WIDTH: write data.
- `busy_o` out 1: high from start acceptance until `done_o`.
- `done_o` out 1: one-cycle pulse after the last write.
- `sat_o` out 1: sticky flag set when a source addition saturated; cleared on start.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE**
  - On `start_i`: latch `n_cells_i`, `pec_en_i`, `src_en_i`, `src_idx_i`, `src_val_i`; clear the issue and write counters; clear `sat_o`.
  - Go to RUN, or to DONE if `n_cells_i`==0.
- **RUN**
  - Each `clken_i` with issue count < n_cells pushes a 1 into the tag delay line; the issue counter then increments.
  - `clken_i` beyond n_cells, or while in IDLE or DONE, pushes 0 and is ignored.
  - When the tag emerges, the stage samples `ez_n_i` at index = write counter, computes the write value, registers it onto the write port, and increments the write counter.
  - Writing index n_cells-1 moves the FSM to DONE.
- **DONE**: `done_o`=1 for one cycle, then IDLE.
- **Write value**, in priority order:
  - PEC and (index==0 or index==n_cells-1): write 0.
  - Source enabled and index==src_idx: saturating signed add `ez_n_i + src_val`. The sum is computed at FDTD_DATA_WIDTH+1 bits and clamped to the signed max or min; any clamp sets `sat_o`.
  - Otherwise: `ez_n_i` unchanged.
- `start_i` while busy is ignored; the latched parameters do not change.
- A `src_idx` ≥ n_cells never matches.
- Gaps in `clken_i` are legal; writes follow the same gap pattern.

## Timing
- Reset values:
  - All outputs are 0 and the FSM is in IDLE.
  - Counters and the tag line are cleared.
  - Asserting reset mid-sweep aborts the sweep: no further writes and no `done_o`.
- Latency: `clken_i` at cycle t gives `wr_en_o` at t+CALC_LATENCY+1, with `wr_addr_o` and `wr_data_o` valid in the same cycle.
- Throughput: one write per cycle when `clken_i` is held high.
- `busy_o` rises the cycle after start acceptance.
- `done_o` is asserted the cycle after the last `wr_en_o`. `busy_o` falls in the same cycle as that `done_o`.
- For n_cells==0: `done_o` is asserted 1 cycle after start, with no writes.
- The write port is registered only; there is no combinational path from `ez_n_i` to the outputs.

## Structure
- `fdtd_pkg` holds:
  - the FSM state enum;
  - the saturation constants `FDTD_MAX` / `FDTD_MIN`, derived from FDTD_DATA_WIDTH;
  - the saturating-add function, shared with the future Hy writeback.
- The valid tag line reuses the existing `fdtd_data_delay` with FDTD_DATA_WIDTH=1 and DELAY_STAGE=CALC_LATENCY. There is no other sub-module.

## Test plan
- Basic sweep:
  - Stimulus: n_cells=5, PEC and source off, `clken` high for 5 cycles, `ez_n` values 10, 20, 30, 40, 50.
  - Response: writes at addresses 0–4 with the same data, first write at CALC_LATENCY+1, `done_o` one cycle after the last write.
- PEC:
  - Stimulus: n_cells=4, `pec_en`=1, inputs 7, 8, 9, 10.
  - Response: data written is 0, 8, 9, 0.
- Source saturation:
  - Stimulus: src_idx=2, src_val=0x7FFF_FFF0, `ez_n` at cell 2 = 0x20.
  - Response: cell 2 is written as 0x7FFF_FFFF and `sat_o`=1. A following start clears `sat_o`.
- Gapped clken plus excess:
  - Stimulus: n_cells=3, `clken` pattern 1,0,1,1,1.
  - Response: exactly 3 writes with matching gaps; the 4th `clken` is ignored; start pulses during the run are ignored.
- Zero cells:
  - Stimulus: n_cells=0.
  - Response: `done_o` 1 cycle after start, no `wr_en_o`.
- Reset mid-sweep:
  - Stimulus: RST_N low after 2 of 6 writes.
  - Response: all outputs 0 immediately. A new sweep after release behaves exactly like the basic sweep.
